// File: rtl/mem_bus_tester_pkg.sv
// Local state encodings for the march-test initiator.
// pass_t is the test pass, sub_t the per-request substate.
package mem_bus_tester_pkg;

    typedef enum logic [2:0] {
        IDLE,
        W_UP,
        R_UP,
        W_DN,
        R_DN,
        DONE
    } pass_t;

    typedef enum logic {
        ISSUE,
        WAIT
    } sub_t;

endpackage

// File: rtl/mem_pkg.sv
// Shared MemBus package: request opcodes and default bus widths.
// Used by the tester and by the Mem and Cache responders.
package MemPkg;

    localparam int ADDR_WIDTH = 6;
    localparam int DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        NOP   = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10
    } op_t;

endpackage

// File: rtl/mem_bus.sv
// MemBus: single-outstanding request/response bus.
// tx_bp drives requests and takes responses; rx_bp is the responder side.
interface MemBus #(
    parameter int ADDR_WIDTH = MemPkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = MemPkg::DATA_WIDTH
);

    MemPkg::op_t           req_op;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_data;
    logic                  rsp_vld;
    logic [DATA_WIDTH-1:0] rsp_data;

    modport tx_bp (
        output req_op,
        output req_addr,
        output req_data,
        input  rsp_vld,
        input  rsp_data
    );

    modport rx_bp (
        input  req_op,
        input  req_addr,
        input  req_data,
        output rsp_vld,
        output rsp_data
    );

endinterface

// File: rtl/mem_bus_timeout.sv
// Loadable 16-bit up-counter used as the response watchdog.
// Ports: clk, rst, clear, load/load_val, en; expired when count == LIMIT.
module mem_bus_timeout #(
    parameter int unsigned LIMIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        en,
    output logic        expired
);

    logic [15:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= count + 16'd1;
        end
    end

    assign expired = (count == 16'(LIMIT));

endmodule

// File: rtl/mem_bus_tester.sv
// Four-pass march tester driving a MemBus responder; counts read errors and timeouts.
// Ports: clk, rst, start, bp (MemBus.tx_bp), busy, done, pass, err_count, err_addr.
module mem_bus_tester #(
    parameter int          ADDR_WIDTH = MemPkg::ADDR_WIDTH,
    parameter int          DATA_WIDTH = MemPkg::DATA_WIDTH,
    parameter int unsigned SEED       = 32'h5A,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    MemBus.tx_bp                  bp,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [15:0]           err_count,
    output logic [ADDR_WIDTH-1:0] err_addr
);

    import MemPkg::*;
    import mem_bus_tester_pkg::*;

    function automatic logic [DATA_WIDTH-1:0] pat(input logic [ADDR_WIDTH-1:0] a);
        return DATA_WIDTH'(a) ^ DATA_WIDTH'(SEED);
    endfunction

    pass_t                 phase, phase_n;
    sub_t                  sub, sub_n;
    logic [ADDR_WIDTH-1:0] addr, addr_n;
    op_t                   op_q, op_n;
    logic [DATA_WIDTH-1:0] data_q, data_n;
    logic [15:0]           err_n;
    logic [ADDR_WIDTH-1:0] eaddr_n;
    logic                  busy_n, done_n, pass_n;

    logic                  running, waiting, got, tmo, err_hit;
    logic                  is_read, is_down, last, expired;
    logic [DATA_WIDTH-1:0] expect_d;

    assign running = (phase != IDLE) && (phase != DONE);
    assign waiting = running && (sub == WAIT);
    assign is_read = (phase == R_UP) || (phase == R_DN);
    assign is_down = (phase == W_DN) || (phase == R_DN);
    assign expect_d = is_down ? ~pat(addr) : pat(addr);
    assign last = is_down ? (addr == '0) : (addr == '1);

    // A late response is taken as an answer only while waiting.
    assign got = waiting && bp.rsp_vld;
    assign tmo = waiting && !bp.rsp_vld && expired;
    assign err_hit = (got && is_read && (bp.rsp_data != expect_d)) || tmo;

    mem_bus_timeout #(
        .LIMIT(TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (!waiting),
        .load    (1'b0),
        .load_val(16'd0),
        .en      (waiting),
        .expired (expired)
    );

    always_comb begin
        phase_n = phase;
        sub_n   = sub;
        addr_n  = addr;
        err_n   = err_count;
        eaddr_n = err_addr;

        if (start && !running) begin
            phase_n = W_UP;
            sub_n   = ISSUE;
            addr_n  = '0;
            err_n   = '0;
            eaddr_n = '0;
        end else if (running) begin
            if (sub == ISSUE) begin
                sub_n = WAIT;
            end else if (got || tmo) begin
                sub_n = ISSUE;
                if (last) begin
                    unique case (phase)
                        W_UP: begin
                            phase_n = R_UP;
                            addr_n  = '0;
                        end
                        R_UP: begin
                            phase_n = W_DN;
                            addr_n  = '1;
                        end
                        W_DN: begin
                            phase_n = R_DN;
                            addr_n  = '1;
                        end
                        R_DN: phase_n = DONE;
                        default: phase_n = phase;
                    endcase
                end else begin
                    addr_n = is_down ? addr - 1'b1 : addr + 1'b1;
                end
            end
            if (err_hit) begin
                if (err_count == '0) begin
                    eaddr_n = addr;
                end
                if (err_count != 16'hFFFF) begin
                    err_n = err_count + 16'd1;
                end
            end
        end

        op_n   = NOP;
        data_n = '0;
        if (sub_n == ISSUE) begin
            unique case (phase_n)
                W_UP: begin
                    op_n   = WRITE;
                    data_n = pat(addr_n);
                end
                R_UP: op_n = READ;
                W_DN: begin
                    op_n   = WRITE;
                    data_n = ~pat(addr_n);
                end
                R_DN: op_n = READ;
                default: op_n = NOP;
            endcase
        end

        busy_n = (phase_n != IDLE) && (phase_n != DONE);
        done_n = (phase_n == DONE);
        pass_n = done_n && (err_n == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase     <= IDLE;
            sub       <= ISSUE;
            addr      <= '0;
            op_q      <= NOP;
            data_q    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            err_addr  <= '0;
        end else begin
            phase     <= phase_n;
            sub       <= sub_n;
            addr      <= addr_n;
            op_q      <= op_n;
            data_q    <= data_n;
            busy      <= busy_n;
            done      <= done_n;
            pass      <= pass_n;
            err_count <= err_n;
            err_addr  <= eaddr_n;
        end
    end

    assign bp.req_op   = op_q;
    assign bp.req_addr = addr;
    assign bp.req_data = data_q;

endmodule

// File: tb/tb_mem_bus_tester.sv
// Directed bench for mem_bus_tester with a configurable responder model.
// Covers timing, fault injection, dropped responses, random latency, reset and restart.
module tb_mem_bus_tester;

    import MemPkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] err_count;
    logic [5:0]  err_addr;

    int total;
    int bad;

    MemBus #(.ADDR_WIDTH(6), .DATA_WIDTH(8)) bp ();

    mem_bus_tester #(
        .ADDR_WIDTH(6),
        .DATA_WIDTH(8),
        .SEED      (32'h5A),
        .TIMEOUT   (255)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bp       (bp),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .err_count(err_count),
        .err_addr (err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // responder configuration, written only by the main initial block
    int fix_lat;
    bit rnd_lat;
    bit fault;
    bit drop;

    // responder state
    logic [7:0] mem [64];
    bit         pend;
    int         cd;
    int         rl;
    logic [7:0] pdata;
    int         lat_now;
    logic [7:0] rdat;

    assign lat_now = rnd_lat ? rl : fix_lat;
    assign rdat = (bp.req_op == READ) ?
        (mem[bp.req_addr] ^ ((fault && bp.req_addr == 6'd5) ? 8'h01 : 8'h00)) : 8'h00;

    always @(posedge clk) begin
        rl <= int'($urandom_range(1, 10));
        bp.rsp_vld <= 1'b0;
        if (pend) begin
            if (cd <= 1) begin
                bp.rsp_vld  <= 1'b1;
                bp.rsp_data <= pdata;
                pend        <= 1'b0;
            end else begin
                cd <= cd - 1;
            end
        end
        if (bp.req_op != NOP) begin
            if (bp.req_op == WRITE) mem[bp.req_addr] <= bp.req_data;
            if (!(drop && bp.req_op == WRITE && bp.req_addr == 6'd0 && bp.req_data == 8'h5A)) begin
                if (lat_now <= 1) begin
                    bp.rsp_vld  <= 1'b1;
                    bp.rsp_data <= rdat;
                end else begin
                    pend  <= 1'b1;
                    cd    <= lat_now - 1;
                    pdata <= rdat;
                end
            end
        end
    end

    // bus monitor, sampled on the falling edge
    int         mcyc;
    int         n_req;
    int         n_rsp;
    int         n_viol;
    bit         outstanding;
    logic [5:0] req_q [$];
    int         req_t [$];

    always @(negedge clk) begin
        mcyc = mcyc + 1;
        if (rst) begin
            outstanding = 1'b0;
        end else begin
            if (bp.req_op != NOP) begin
                req_q.push_back(bp.req_addr);
                req_t.push_back(mcyc);
                n_req = n_req + 1;
                if (outstanding) n_viol = n_viol + 1;
                outstanding = 1'b1;
            end
            if (bp.rsp_vld) begin
                n_rsp = n_rsp + 1;
                outstanding = 1'b0;
            end
        end
    end

    task automatic run_to_done(output int cyc);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (bp.req_op !== NOP) begin
            bad++;
            $display("FAIL reset_op got=%0d want=0", bp.req_op);
        end
        total++;
        if (bp.req_addr !== 6'd0 || bp.req_data !== 8'd0) begin
            bad++;
            $display("FAIL reset_addr_data got=%h/%h want=0/0", bp.req_addr, bp.req_data);
        end
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b%b%b want=000", busy, done, pass);
        end
        total++;
        if (err_count !== 16'd0 || err_addr !== 6'd0) begin
            bad++;
            $display("FAIL reset_err got=%0d/%0d want=0/0", err_count, err_addr);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b0 || bp.req_op !== NOP) begin
            bad++;
            $display("FAIL idle_hold got busy=%b op=%0d want 0/0", busy, bp.req_op);
        end
    endtask

    task automatic test_full();
        int cyc;
        fix_lat = 1;
        rnd_lat = 0;
        fault = 0;
        drop = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        total++;
        if (bp.req_op !== WRITE || bp.req_addr !== 6'd0 || bp.req_data !== 8'h5A) begin
            bad++;
            $display("FAIL first_req got=%0d/%h/%h want=2/00/5a", bp.req_op, bp.req_addr, bp.req_data);
        end
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL busy_rise got=%b want=1", busy);
        end
        @(negedge clk);
        cyc = 2;
        total++;
        if (bp.req_op !== NOP) begin
            bad++;
            $display("FAIL wait_nop got=%0d want=0", bp.req_op);
        end
        @(negedge clk);
        cyc = 3;
        total++;
        if (bp.req_op !== WRITE || bp.req_addr !== 6'd1 || bp.req_data !== 8'h5B) begin
            bad++;
            $display("FAIL second_req got=%0d/%h/%h want=2/01/5b", bp.req_op, bp.req_addr, bp.req_data);
        end
        while (!done && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (cyc !== 513) begin
            bad++;
            $display("FAIL full_time got=%0d want=513", cyc);
        end
        total++;
        if (busy !== 1'b0 || pass !== 1'b1) begin
            bad++;
            $display("FAIL full_flags got busy=%b pass=%b want 0/1", busy, pass);
        end
        total++;
        if (err_count !== 16'd0 || err_addr !== 6'd0) begin
            bad++;
            $display("FAIL full_err got=%0d/%0d want=0/0", err_count, err_addr);
        end
    endtask

    task automatic test_fault();
        int cyc;
        fix_lat = 1;
        fault = 1;
        run_to_done(cyc);
        fault = 0;
        total++;
        if (cyc !== 513) begin
            bad++;
            $display("FAIL fault_time got=%0d want=513", cyc);
        end
        total++;
        if (err_count !== 16'd2) begin
            bad++;
            $display("FAIL fault_count got=%0d want=2", err_count);
        end
        total++;
        if (err_addr !== 6'd5) begin
            bad++;
            $display("FAIL fault_addr got=%0d want=5", err_addr);
        end
        total++;
        if (pass !== 1'b0 || done !== 1'b1) begin
            bad++;
            $display("FAIL fault_pass got pass=%b done=%b want 0/1", pass, done);
        end
    endtask

    task automatic test_rerun();
        int cyc;
        fix_lat = 1;
        fault = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        total++;
        if (err_count !== 16'd0 || err_addr !== 6'd0) begin
            bad++;
            $display("FAIL rerun_clear got=%0d/%0d want=0/0", err_count, err_addr);
        end
        total++;
        if (done !== 1'b0 || pass !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL rerun_flags got d=%b p=%b b=%b want 0/0/1", done, pass, busy);
        end
        total++;
        if (bp.req_op !== WRITE || bp.req_addr !== 6'd0) begin
            bad++;
            $display("FAIL rerun_req got=%0d/%0d want=2/0", bp.req_op, bp.req_addr);
        end
        while (!done && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (cyc !== 513) begin
            bad++;
            $display("FAIL rerun_time got=%0d want=513", cyc);
        end
        total++;
        if (pass !== 1'b1 || err_count !== 16'd0) begin
            bad++;
            $display("FAIL rerun_result got pass=%b err=%0d want 1/0", pass, err_count);
        end
    endtask

    task automatic test_drop();
        int cyc;
        int qb;
        fix_lat = 1;
        drop = 1;
        qb = req_t.size();
        run_to_done(cyc);
        drop = 0;
        total++;
        if (req_t.size() < qb + 2) begin
            bad++;
            $display("FAIL drop_reqs got=%0d want>=2", req_t.size() - qb);
        end else if (req_t[qb + 1] - req_t[qb] - 1 !== 256) begin
            bad++;
            $display("FAIL drop_wait got=%0d want=256", req_t[qb + 1] - req_t[qb] - 1);
        end
        total++;
        if (cyc !== 768) begin
            bad++;
            $display("FAIL drop_time got=%0d want=768", cyc);
        end
        total++;
        if (err_count !== 16'd1 || err_addr !== 6'd0) begin
            bad++;
            $display("FAIL drop_err got=%0d/%0d want=1/0", err_count, err_addr);
        end
        total++;
        if (pass !== 1'b0) begin
            bad++;
            $display("FAIL drop_pass got=%b want=0", pass);
        end
    endtask

    task automatic test_random_latency();
        int cyc;
        int qb;
        int r0;
        int s0;
        int v0;
        int miss;
        logic [5:0] expq [$];
        rnd_lat = 1;
        qb = req_q.size();
        r0 = n_req;
        s0 = n_rsp;
        v0 = n_viol;
        for (int i = 0; i < 64; i++) expq.push_back(6'(i));
        for (int i = 0; i < 64; i++) expq.push_back(6'(i));
        for (int i = 63; i >= 0; i--) expq.push_back(6'(i));
        for (int i = 63; i >= 0; i--) expq.push_back(6'(i));
        run_to_done(cyc);
        @(negedge clk);
        rnd_lat = 0;
        total++;
        if (cyc >= 20000) begin
            bad++;
            $display("FAIL rand_done got=%0d cycles want=<20000", cyc);
        end
        total++;
        if (n_req - r0 !== 256) begin
            bad++;
            $display("FAIL rand_reqs got=%0d want=256", n_req - r0);
        end
        total++;
        if (n_rsp - s0 !== n_req - r0) begin
            bad++;
            $display("FAIL rand_rsps got=%0d want=%0d", n_rsp - s0, n_req - r0);
        end
        total++;
        if (n_viol - v0 !== 0) begin
            bad++;
            $display("FAIL rand_wait_nop got=%0d want=0", n_viol - v0);
        end
        miss = 0;
        for (int i = 0; i < 256; i++) begin
            if (qb + i >= req_q.size()) miss++;
            else if (req_q[qb + i] !== expq[i]) miss++;
        end
        total++;
        if (miss !== 0) begin
            bad++;
            $display("FAIL rand_order got=%0d wrong want=0", miss);
        end
        total++;
        if (pass !== 1'b1 || err_count !== 16'd0) begin
            bad++;
            $display("FAIL rand_result got pass=%b err=%0d want 1/0", pass, err_count);
        end
    endtask

    task automatic test_start_busy();
        int cyc;
        int r0;
        fix_lat = 1;
        r0 = n_req;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        repeat (99) begin
            @(negedge clk);
            cyc++;
        end
        start = 1'b1;
        @(negedge clk);
        cyc++;
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || err_count !== 16'd0) begin
            bad++;
            $display("FAIL busy_start got busy=%b err=%0d want 1/0", busy, err_count);
        end
        while (!done && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (cyc !== 513) begin
            bad++;
            $display("FAIL busy_time got=%0d want=513", cyc);
        end
        total++;
        if (n_req - r0 !== 256 || pass !== 1'b1) begin
            bad++;
            $display("FAIL busy_run got reqs=%0d pass=%b want 256/1", n_req - r0, pass);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        fix_lat = 3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!(bp.req_op == READ && bp.req_addr == 6'd20) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (cyc >= 20000) begin
            bad++;
            $display("FAIL mid_reach got=%0d cycles want=<20000", cyc);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (bp.req_op !== NOP || bp.req_addr !== 6'd0 || bp.req_data !== 8'd0) begin
            bad++;
            $display("FAIL mid_req got=%0d/%h/%h want=0/00/00", bp.req_op, bp.req_addr, bp.req_data);
        end
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin
            bad++;
            $display("FAIL mid_flags got=%b%b%b want=000", busy, done, pass);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        total++;
        if (err_count !== 16'd0 || busy !== 1'b0 || bp.req_op !== NOP) begin
            bad++;
            $display("FAIL mid_stray got err=%0d busy=%b op=%0d want 0/0/0", err_count, busy, bp.req_op);
        end
        fix_lat = 1;
    endtask

    initial begin
        total = 0;
        bad = 0;
        fix_lat = 1;
        rnd_lat = 0;
        fault = 0;
        drop = 0;
        test_reset();
        test_full();
        test_fault();
        test_rerun();
        test_drop();
        test_random_latency();
        test_start_busy();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
